// File: rtl/dual_issue_scheduler.sv
// Dual-issue scheduler: buffers one decoded pair and issues it to a full way and an ALU-only way.
// Optional SCHED_PERF_CNT_EN adds dual/split issue counters.
module dual_issue_scheduler (
    input  logic        clk,
    input  logic        rstn_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [31:0] instr0_i,
    input  logic [31:0] instr1_i,
    input  logic        slot1_v_i,
    input  logic [31:0] pc_i,
    input  logic        mem0_i,
    input  logic        mem1_i,
    input  logic        ctrl0_i,
    input  logic        wr0_i,
    input  logic        wr1_i,
    input  logic        stall_i,
    input  logic        flush_i,
    output logic        w1_v_o,
    output logic        w2_v_o,
    output logic [31:0] w1_instr_o,
    output logic [31:0] w2_instr_o,
    output logic [31:0] w1_pc_o,
    output logic [31:0] w2_pc_o,
    output logic        order_change_o
`ifdef SCHED_PERF_CNT_EN
    ,
    output logic [31:0] dual_cnt_o,
    output logic [31:0] split_cnt_o
`endif
);

    // state  | meaning
    // EMPTY  | no pair buffered
    // FULL   | pair buffered, nothing issued yet
    // SECOND | instr0 issued alone, instr1 still pending
    typedef enum logic [1:0] {ST_EMPTY, ST_FULL, ST_SECOND} state_t;

    typedef struct packed {
        logic [31:0] instr0;
        logic [31:0] instr1;
        logic [31:0] pc;
        logic        slot1_v;
        logic        mem0;
        logic        mem1;
        logic        ctrl0;
        logic        wr0;
        logic        wr1;
    } pair_t;

    state_t      state_q, state_d;
    pair_t       buf_q, buf_d;
    logic        live_q;
    logic        accept;
    logic        dual;
    logic        raw;
    logic        waw;
    logic [4:0]  rd0, rd1, rs1_1, rs2_1;
    logic [31:0] pc_plus4;

    assign rd0      = buf_q.instr0[11:7];
    assign rd1      = buf_q.instr1[11:7];
    assign rs1_1    = buf_q.instr1[19:15];
    assign rs2_1    = buf_q.instr1[24:20];
    assign pc_plus4 = buf_q.pc + 32'd4;

    assign raw  = buf_q.wr0 && (rd0 != 5'd0) && ((rd0 == rs1_1) || (rd0 == rs2_1));
    assign waw  = buf_q.wr0 && buf_q.wr1 && (rd0 != 5'd0) && (rd0 == rd1);
    assign dual = buf_q.slot1_v && !(buf_q.mem0 && buf_q.mem1) && !buf_q.ctrl0 && !raw && !waw;

    // live_q keeps in_ready_o low until the first edge after reset release
    assign in_ready_o = live_q && !flush_i &&
                        ((state_q == ST_EMPTY) ||
                         ((state_q == ST_FULL) && dual && !stall_i) ||
                         ((state_q == ST_SECOND) && !stall_i));
    assign accept = in_valid_i && in_ready_o;

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= ST_EMPTY;
            buf_q   <= '0;
            live_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            live_q  <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        if (flush_i) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) state_d = ST_FULL;
                end
                ST_FULL: begin
                    if (!stall_i) begin
                        if (dual)                 state_d = accept ? ST_FULL : ST_EMPTY;
                        else if (buf_q.slot1_v)   state_d = ST_SECOND;
                        else                      state_d = ST_EMPTY;
                    end
                end
                ST_SECOND: begin
                    if (!stall_i) state_d = accept ? ST_FULL : ST_EMPTY;
                end
                default: state_d = ST_EMPTY;
            endcase
            if (accept) begin
                buf_d.instr0  = instr0_i;
                buf_d.instr1  = instr1_i;
                buf_d.pc      = pc_i;
                buf_d.slot1_v = slot1_v_i;
                buf_d.mem0    = mem0_i;
                buf_d.mem1    = mem1_i;
                buf_d.ctrl0   = ctrl0_i;
                buf_d.wr0     = wr0_i;
                buf_d.wr1     = wr1_i;
            end
        end
    end

    // Data outputs are zero in EMPTY so reset presents an all-zero interface
    always_comb begin
        w1_v_o         = 1'b0;
        w2_v_o         = 1'b0;
        w1_instr_o     = '0;
        w2_instr_o     = '0;
        w1_pc_o        = '0;
        w2_pc_o        = '0;
        order_change_o = 1'b0;
        case (state_q)
            ST_FULL: begin
                w1_v_o     = 1'b1;
                w1_instr_o = buf_q.instr0;
                w1_pc_o    = buf_q.pc;
                if (dual) begin
                    w2_v_o = 1'b1;
                    if (buf_q.mem1) begin
                        w1_instr_o     = buf_q.instr1;
                        w1_pc_o        = pc_plus4;
                        w2_instr_o     = buf_q.instr0;
                        w2_pc_o        = buf_q.pc;
                        order_change_o = 1'b1;
                    end else begin
                        w2_instr_o = buf_q.instr1;
                        w2_pc_o    = pc_plus4;
                    end
                end
            end
            ST_SECOND: begin
                w1_v_o     = 1'b1;
                w1_instr_o = buf_q.instr1;
                w1_pc_o    = pc_plus4;
            end
            default: ;
        endcase
        if (flush_i) begin
            w1_v_o = 1'b0;
            w2_v_o = 1'b0;
        end
    end

`ifdef SCHED_PERF_CNT_EN
    logic issue_ok;
    assign issue_ok = (state_q == ST_FULL) && !stall_i && !flush_i;

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            dual_cnt_o  <= '0;
            split_cnt_o <= '0;
        end else begin
            if (issue_ok && dual)                    dual_cnt_o  <= dual_cnt_o + 32'd1;
            if (issue_ok && !dual && buf_q.slot1_v)  split_cnt_o <= split_cnt_o + 32'd1;
        end
    end
`endif

endmodule
